// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dm_lane_unit and dm_responder.
package dm_pkg;

    // funct3 codes, prefixed by the store bit so that loads and stores stay distinct.
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dm_state_e;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic ctrl_illegal(input logic wr, input logic [2:0] funct3);
        if (wr) return funct3[2] || (funct3[1:0] == 2'b11);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane steering: store merge, byte enables, load extension, misalign flag.
// Unknown ctrl codes fall back to full-word access.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic        wr,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] store_word,
    output logic [3:0]  byte_en,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [31:0] repl;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = old_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        repl     = wdata;
        byte_en  = 4'b0000;
        load_val = old_word;
        misalign = 1'b0;
        case ({wr, funct3})
            LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
            LBU: load_val = {24'h0, byte_sel};
            LH: begin
                load_val = {{16{half_sel[15]}}, half_sel};
                misalign = lane[0];
            end
            LHU: begin
                load_val = {16'h0, half_sel};
                misalign = lane[0];
            end
            SB: begin
                repl    = {4{wdata[7:0]}};
                byte_en = BE_BYTE << lane;
            end
            SH: begin
                repl     = {2{wdata[15:0]}};
                byte_en  = lane[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign = lane[0];
            end
            default: begin
                // LW, SW and every illegal code: whole word
                byte_en  = wr ? BE_WORD : 4'b0000;
                misalign = |lane;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            store_word[i*8 +: 8] = byte_en[i] ? repl[i*8 +: 8] : old_word[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Optional error checking is enabled by defining DM_ERR_CHECK_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output dm_state_e   dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and rsp_valid is a single-cycle strobe in RESP.

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_e   state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] addr_q;
    logic        wr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] old_word, store_word, load_val;
    logic [3:0]  byte_en;
    logic        misalign, acc_err, mem_we;

    assign idx      = addr_q[AW+1:2];
    assign old_word = mem[idx];

    dm_lane_unit u_lane (
        .wr         (wr_q),
        .funct3     (ctrl_q),
        .lane       (addr_q[1:0]),
        .wdata      (wdata_q),
        .old_word   (old_word),
        .store_word (store_word),
        .byte_en    (byte_en),
        .load_val   (load_val),
        .misalign   (misalign)
    );

`ifdef DM_ERR_CHECK_EN
    assign acc_err = misalign || ctrl_illegal(wr_q, ctrl_q) ||
                     (addr_q[31:2] >= 30'(DEPTH_WORDS));
`else
    // Upper address bits and the misalign flag only matter when checking is on.
    logic unused_bits;
    assign acc_err     = 1'b0;
    assign unused_bits = ^{addr_q[31:AW+2], misalign};
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;
    assign mem_we    = (state == ACCESS) && wr_q && !acc_err && (|byte_en);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_d = ACCESS;
                else             cnt_d   = cnt - 4'd1;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            ctrl_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wr_q    <= req_wr;
                ctrl_q  <= req_ctrl;
                wdata_q <= req_wdata;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (wr_q || acc_err) ? 32'h0 : load_val;
                rsp_err   <= acc_err;
            end else if (state == RESP) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= store_word;
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed tables, a random byte/word mix
// against a small memory model, handshake timing and mid-operation reset.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int WAIT_CYCLES = 2;
  localparam int LAT         = WAIT_CYCLES + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [2:0]  req_ctrl = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  dm_state_e   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } op_t;

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wr    (req_wr),
    .req_ctrl  (req_ctrl),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one request, returns the response and its latency (-1 on timeout)
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_ctrl  = f3;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        lat   = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", rsp_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", rsp_err); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_word();
    op_t ops[$];
    ops.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    foreach (ops[i]) begin
      logic [31:0] rd; logic er; int lat; logic [32:0] e;
      exp_q.push_back({ops[i].err, ops[i].rdata});
      run_req(ops[i].wr, ops[i].f3, ops[i].addr, ops[i].wdata, rd, er, lat);
      e = exp_q.pop_front();
      total++; if ({er, rd} !== e) begin bad++; $display("FAIL word[%0d] got err=%0b rdata=%h want err=%0b rdata=%h", i, er, rd, e[32], e[31:0]); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL word_lat[%0d] got=%0d want=%0d", i, lat, LAT); end
    end
    @(negedge clk);
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rdata_clear got=%h want=0", rsp_rdata); end
  endtask

  task automatic test_byte_half();
    op_t ops[$];
    ops.push_back('{1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0});
    ops.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0});
    ops.push_back('{1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0});
    ops.push_back('{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0});
    ops.push_back('{1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0});
    foreach (ops[i]) begin
      logic [31:0] rd; logic er; int lat; logic [32:0] e;
      exp_q.push_back({ops[i].err, ops[i].rdata});
      run_req(ops[i].wr, ops[i].f3, ops[i].addr, ops[i].wdata, rd, er, lat);
      e = exp_q.pop_front();
      total++; if ({er, rd} !== e) begin bad++; $display("FAIL byte_half[%0d] got err=%0b rdata=%h want err=%0b rdata=%h", i, er, rd, e[32], e[31:0]); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL byte_half_lat[%0d] got=%0d want=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
`ifdef DM_ERR_CHECK_EN
    ops.push_back('{1'b1, 3'b010, 32'h11, 32'hDEADDEAD, 32'h0, 1'b1});
    ops.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1});
    ops.push_back('{1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1});
    ops.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1});
    ops.push_back('{1'b1, 3'b100, 32'h10, 32'h0BADF00D, 32'h0, 1'b1});
    ops.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0});
`else
    ops.push_back('{1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 32'hCAFEF00D, 1'b0});
    ops.push_back('{1'b1, 3'b010, 32'h31, 32'hA5A5A5A5, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0});
    ops.push_back('{1'b0, 3'b001, 32'h13, 32'h0, 32'h00001234, 1'b0});
    ops.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 32'h1234BEEF, 1'b0});
    ops.push_back('{1'b1, 3'b111, 32'h30, 32'h01020304, 32'h0, 1'b0});
    ops.push_back('{1'b0, 3'b010, 32'h30, 32'h0, 32'h01020304, 1'b0});
`endif
    foreach (ops[i]) begin
      logic [31:0] rd; logic er; int lat; logic [32:0] e;
      exp_q.push_back({ops[i].err, ops[i].rdata});
      run_req(ops[i].wr, ops[i].f3, ops[i].addr, ops[i].wdata, rd, er, lat);
      e = exp_q.pop_front();
      total++; if ({er, rd} !== e) begin bad++; $display("FAIL edge_case[%0d] got err=%0b rdata=%h want err=%0b rdata=%h", i, er, rd, e[32], e[31:0]); end
    end
  endtask

  // request held high through RESP must be taken only in the following IDLE cycle
  task automatic test_hold();
    logic [31:0] rd; logic er; int lat; logic [32:0] e;
    exp_q.push_back({1'b0, 32'h0});
    run_req(1'b1, 3'b010, 32'h40, 32'h00000077, rd, er, lat);
    e = exp_q.pop_front();
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL hold_store got err=%0b rdata=%h want err=%0b rdata=%h", er, rd, e[32], e[31:0]); end
    req_valid = 1'b1; req_wr = 1'b0; req_ctrl = 3'b010; req_addr = 32'h40; req_wdata = '0;
    exp_q.push_back({1'b0, 32'h00000077});
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_resp_ready got=%0b want=0", req_ready); end
    @(negedge clk);
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL hold_idle got=%0d want=%0d", dbg_state, IDLE); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL hold_accept got=%0d want=%0d", dbg_state, WAIT); end
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; lat = i; break; end
    end
    e = exp_q.pop_front();
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL hold_load got err=%0b rdata=%h want err=%0b rdata=%h", er, rd, e[32], e[31:0]); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL hold_lat got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [31:0] mdl [16];
    for (int k = 0; k < 16; k++) begin
      logic [31:0] rd; logic er; int lat; logic [32:0] e;
      mdl[k] = $urandom;
      exp_q.push_back({1'b0, 32'h0});
      run_req(1'b1, 3'b010, 32'h100 + 32'(k * 4), mdl[k], rd, er, lat);
      e = exp_q.pop_front();
      total++; if ({er, rd} !== e) begin bad++; $display("FAIL rand_fill[%0d] got err=%0b rdata=%h want err=%0b rdata=%h", k, er, rd, e[32], e[31:0]); end
    end
    for (int n = 0; n < 30; n++) begin
      logic [31:0] rd, data, addr, want; logic er; int lat, k, lane, op; logic [32:0] e;
      logic [7:0] b;
      op   = $urandom_range(0, 3);
      k    = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      data = $urandom;
      addr = 32'h100 + 32'(k * 4);
      want = 32'h0;
      case (op)
        0: mdl[k] = data;
        1: begin addr = addr + 32'(lane); mdl[k][8*lane +: 8] = data[7:0]; end
        2: want = mdl[k];
        default: begin
          addr = addr + 32'(lane);
          b    = mdl[k][8*lane +: 8];
          want = {{24{b[7]}}, b};
        end
      endcase
      exp_q.push_back({1'b0, want});
      run_req(op < 2, (op == 1 || op == 3) ? 3'b000 : 3'b010, addr, data, rd, er, lat);
      e = exp_q.pop_front();
      total++; if ({er, rd} !== e) begin bad++; $display("FAIL rand[%0d] op=%0d addr=%h got err=%0b rdata=%h want err=%0b rdata=%h", n, op, addr, er, rd, e[32], e[31:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic [32:0] e;
    exp_q.push_back({1'b0, 32'h0});
    run_req(1'b1, 3'b010, 32'h20, 32'h11111111, rd, er, lat);
    e = exp_q.pop_front();
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL rst_pre got err=%0b rdata=%h want err=%0b rdata=%h", er, rd, e[32], e[31:0]); end
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_ctrl = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL rst_in_wait got=%0d want=%0d", dbg_state, WAIT); end
    rst_n = 1'b0;
    #1;
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_async got=%0d want=%0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp[%0d] got=%0b want=0", i, rsp_valid); end
    end
    exp_q.push_back({1'b0, 32'h11111111});
    run_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    e = exp_q.pop_front();
    total++; if ({er, rd} !== e) begin bad++; $display("FAIL rst_keep got err=%0b rdata=%h want err=%0b rdata=%h", er, rd, e[32], e[31:0]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_hold();
    test_random();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
